// File: rtl/lap_capture_reg.sv
// rtl/lap_capture_reg.sv - follow register / lap capture FIFO with valid-ready readout
//
// Purpose: in follow mode (mode = 0) q is a one-cycle registered copy of in.
// In capture mode (mode = 1) each cap strobe pushes in into a DEPTH-entry
// circular FIFO that a consumer drains through q / q_valid / q_ready.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   mode     0 = follow, 1 = capture
//   in       data to follow or capture
//   cap      capture strobe (capture mode only)
//   clr      synchronous clear of FIFO, ovf and follow register
//   q_ready  consumer accepts the head entry
//   q        follow value (mode 0) or FIFO head (mode 1, 0 when empty)
//   q_valid  FIFO head valid (mode 1 and not empty)
//   count    number of stored entries
//   full     count == DEPTH
//   empty    count == 0
//   ovf      sticky: a capture was dropped because the FIFO was full
module lap_capture_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic [WIDTH-1:0]           in,
    input  logic                       cap,
    input  logic                       clr,
    input  logic                       q_ready,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] follow_q, follow_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic full_w;
    logic empty_w;
    logic do_pop;
    logic do_push;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // A pop is only possible from a non-empty FIFO, so an empty FIFO never
    // bypasses a same-cycle push to the consumer.
    assign do_pop  = mode && !empty_w && q_ready;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_push = mode && cap && (!full_w || do_pop);

    always_comb begin
        follow_d = follow_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;
        if (clr) begin
            follow_d = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (!mode) begin
                follow_d = in;
            end
            if (mode && cap && !do_push) begin
                ovf_d = 1'b1;
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = in;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            follow_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            follow_q <= follow_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign q_valid = mode && !empty_w;
    assign q       = mode ? (empty_w ? '0 : mem_q[rd_ptr_q]) : follow_q;
    assign count   = count_q;
    assign full    = full_w;
    assign empty   = empty_w;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_lap_capture_reg.sv
// tb/tb_lap_capture_reg.sv - self-checking bench for lap_capture_reg
module tb_lap_capture_reg;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] in_d = '0;
    logic         cap = 1'b0;
    logic         clr = 1'b0;
    logic         q_ready = 1'b0;
    logic [W-1:0] q;
    logic         q_valid;
    logic [2:0]   count;
    logic         full;
    logic         empty;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue holding the stored laps in order.
    logic [W-1:0] mq [$];
    logic [W-1:0] mfollow;
    bit           movf;

    lap_capture_reg #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in(in_d), .cap(cap), .clr(clr),
        .q_ready(q_ready), .q(q), .q_valid(q_valid), .count(count),
        .full(full), .empty(empty), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        mfollow = '0;
        movf    = 1'b0;
    endtask

    function automatic logic [W-1:0] exp_q();
        if (!mode) return mfollow;
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    // Apply one rising edge to the model from the current inputs, then clock the DUT.
    task automatic tick();
        bit pop, push;
        if (!rst) begin
            model_reset();
        end else if (clr) begin
            mq.delete();
            movf    = 1'b0;
            mfollow = '0;
        end else if (!mode) begin
            mfollow = in_d;
        end else begin
            pop  = q_ready && (mq.size() > 0);
            push = cap && ((mq.size() < D) || pop);
            if (cap && !push) movf = 1'b1;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(in_d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; in_d = 8'h99;
        tick();
        tick();
        #3 rst = 1'b0;
        #1;
        model_reset();
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h expected 00", q); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (ovf !== 1'b0 || full !== 1'b0 || q_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL reset_flags: ovf=%b full=%b q_valid=%b count=%0d expected 0 0 0 0", ovf, full, q_valid, count); end
        rst = 1'b1;
        in_d = 8'hA5;
        tick();
        n_checks++; if (q !== 8'hA5 || q_valid !== 1'b0) begin n_fail++; $display("FAIL follow_a5: q=%h q_valid=%b expected a5 0", q, q_valid); end
        in_d = 8'h3C;
        n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL follow_latency: q=%h expected a5", q); end
        tick();
        n_checks++; if (q !== 8'h3C || q_valid !== 1'b0) begin n_fail++; $display("FAIL follow_3c: q=%h q_valid=%b expected 3c 0", q, q_valid); end
    endtask

    task automatic test_capture_order();
        logic [W-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [W-1:0] nxt  [4] = '{8'h22, 8'h33, 8'h44, 8'h00};
        mode = 1'b1; q_ready = 1'b0; cap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_d = vals[i];
            tick();
            n_checks++; if (q !== 8'h11) begin n_fail++; $display("FAIL fwft_head[%0d]: q=%h expected 11", i, q); end
        end
        cap = 1'b0;
        n_checks++; if (count !== 3'd4 || full !== 1'b1 || q_valid !== 1'b1) begin
            n_fail++; $display("FAIL cap_full: count=%0d full=%b q_valid=%b expected 4 1 1", count, full, q_valid); end
        q_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (q !== nxt[i]) begin n_fail++; $display("FAIL drain[%0d]: q=%h expected %h", i, q, nxt[i]); end
        end
        n_checks++; if (empty !== 1'b1 || q_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL drain_empty: empty=%b q_valid=%b count=%0d expected 1 0 0", empty, q_valid, count); end
        q_ready = 1'b0;
        tick();
        n_checks++; if (q !== 8'h00 || count !== 3'd0) begin n_fail++; $display("FAIL ready_no_valid: q=%h count=%0d expected 00 0", q, count); end
    endtask

    task automatic test_overflow();
        int seen55 = 0;
        mode = 1'b1; q_ready = 1'b0; cap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_d = 8'hA0 + 8'(i);
            tick();
        end
        in_d = 8'h55;
        tick();
        n_checks++; if (ovf !== 1'b1 || count !== 3'd4 || q !== 8'hA0) begin
            n_fail++; $display("FAIL ovf_drop: ovf=%b count=%0d q=%h expected 1 4 a0", ovf, count, q); end
        q_ready = 1'b1;
        tick();
        n_checks++; if (ovf !== 1'b1 || count !== 3'd4 || full !== 1'b1 || q !== 8'hA1) begin
            n_fail++; $display("FAIL full_push_pop: ovf=%b count=%0d full=%b q=%h expected 1 4 1 a1", ovf, count, full, q); end
        cap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (q_valid && q === 8'h55) seen55++;
            tick();
            n_checks++; if (q !== exp_q()) begin n_fail++; $display("FAIL ovf_drain[%0d]: q=%h expected %h", i, q, exp_q()); end
        end
        n_checks++; if (seen55 != 1) begin n_fail++; $display("FAIL ovf_55_once: seen %0d times expected 1", seen55); end
        q_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [W-1:0] got [$];
        mode = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_d = 8'(i); cap = 1'b1; q_ready = (i % 3) != 0;
            if (q_valid && q_ready) got.push_back(q);
            tick();
            n_checks++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, mq.size()); end
        end
        cap = 1'b0; q_ready = 1'b1;
        for (int i = 0; i < 8 && !empty; i++) begin
            got.push_back(q);
            tick();
        end
        n_checks++; if (got.size() != 10) begin n_fail++; $display("FAIL wrap_size: got %0d entries expected 10", got.size()); end
        for (int k = 0; k < got.size() && k < 10; k++) begin
            n_checks++; if (got[k] !== 8'(k + 1)) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h expected %h", k, got[k], 8'(k + 1)); end
        end
        q_ready = 1'b0;
    endtask

    task automatic test_mode_clr();
        mode = 1'b1; q_ready = 1'b0; cap = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_d = 8'h60 + 8'(i);
            tick();
        end
        cap = 1'b0; q_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (count !== 3'd2 || ovf !== 1'b1 || q !== 8'h62) begin
            n_fail++; $display("FAIL mode_setup: count=%0d ovf=%b q=%h expected 2 1 62", count, ovf, q); end
        mode = 1'b0; in_d = 8'h7E; cap = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (q !== 8'h7E || q_valid !== 1'b0 || count !== 3'd2) begin
            n_fail++; $display("FAIL follow_hold: q=%h q_valid=%b count=%0d expected 7e 0 2", q, q_valid, count); end
        mode = 1'b1; cap = 1'b0; q_ready = 1'b0;
        #1;
        n_checks++; if (q !== 8'h62 || q_valid !== 1'b1 || count !== 3'd2) begin
            n_fail++; $display("FAIL mode_return: q=%h q_valid=%b count=%0d expected 62 1 2", q, q_valid, count); end
        clr = 1'b1; cap = 1'b1; in_d = 8'h99;
        tick();
        clr = 1'b0; cap = 1'b0;
        n_checks++; if (count !== 3'd0 || ovf !== 1'b0 || empty !== 1'b1 || q !== 8'h00) begin
            n_fail++; $display("FAIL clr_cap: count=%0d ovf=%b empty=%b q=%h expected 0 0 1 00", count, ovf, empty, q); end
        mode = 1'b0;
        #1;
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL clr_follow: q=%h expected 00", q); end
    endtask

    task automatic test_async_reset();
        mode = 1'b1; q_ready = 1'b0; cap = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_d = 8'hC0 + 8'(i);
            tick();
        end
        cap = 1'b0; q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        n_checks++; if (count !== 3'd3 || ovf !== 1'b1) begin n_fail++; $display("FAIL pre_reset: count=%0d ovf=%b expected 3 1", count, ovf); end
        #3 rst = 1'b0;
        #1;
        model_reset();
        n_checks++; if (q !== 8'h00 || q_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: q=%h q_valid=%b count=%0d empty=%b full=%b ovf=%b expected 00 0 0 1 0 0",
                               q, q_valid, count, empty, full, ovf); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            mode    = $urandom_range(0, 3) != 0;
            cap     = $urandom_range(0, 1);
            q_ready = $urandom_range(0, 2) == 0;
            clr     = $urandom_range(0, 31) == 0;
            in_d    = 8'($urandom);
            tick();
            n_checks++;
            if (q !== exp_q() || q_valid !== (mode && mq.size() > 0) || count !== 3'(mq.size()) ||
                full !== (mq.size() == D) || empty !== (mq.size() == 0) || ovf !== movf) begin
                n_fail++; errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: q=%h qv=%b cnt=%0d full=%b empty=%b ovf=%b expected q=%h qv=%b cnt=%0d ovf=%b",
                             i, q, q_valid, count, full, empty, ovf, exp_q(), (mode && mq.size() > 0), mq.size(), movf);
            end
        end
        clr = 1'b0; cap = 1'b0; q_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_capture_order();
        test_overflow();
        test_wrap();
        test_mode_clr();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lap_capture_reg.md
Name: lap_capture_reg

Overview:
- Parametrised successor to the single-bit D storage element, used by the two-mode timer.
- Two modes:
  - Follow mode: a WIDTH-bit registered copy of the input.
  - Capture mode: on a strobe, the input (for example a running time value) is pushed into a DEPTH-entry lap FIFO. A display or readout stage drains it with a valid/ready handshake.
- Flags report full, empty and sticky overflow.

Parameters:
- WIDTH, 8, data width of in and q.
- DEPTH, 4, number of capture entries; power of 2, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- mode  input  1  0 = follow mode, 1 = capture mode.
- in  input  WIDTH  data to follow or capture.
- cap  input  1  capture strobe, sampled at the rising edge of clk; honoured only when mode = 1.
- clr  input  1  synchronous clear of FIFO, ovf and the follow register.
- q_ready  input  1  consumer accepts the head entry.
- q  output  WIDTH  follow value (mode 0) or FIFO head (mode 1).
- q_valid  output  1  head entry valid; mode = 1 and FIFO not empty.
- count  output  $clog2(DEPTH+1)  number of stored entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- ovf  output  1  sticky: a capture was dropped because the FIFO was full.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Follow register = 0, read pointer = 0, write pointer = 0, count = 0, ovf = 0.
  - Outputs therefore: q = 0, q_valid = 0, empty = 1, full = 0.
  - Storage array contents are don't-care.
  - Deasserting rst takes effect at the next clock edge.
- Storage:
  - Circular buffer with $clog2(DEPTH)-bit read and write pointers that wrap from DEPTH-1 to 0.
  - count is held separately, so the full and empty states are unambiguous.
- Follow mode (mode = 0):
  - Follow register <= in on every rising edge; 1-cycle latency; q = follow register.
  - q_valid = 0. cap and q_ready are ignored.
  - FIFO contents, count and ovf are retained unchanged.
- Capture mode (mode = 1):
  - Push: cap = 1 and count < DEPTH -> mem[wr_ptr] <= in, wr_ptr increments.
  - Pop: q_valid = 1 and q_ready = 1 -> rd_ptr increments.
  - q is a combinational read of mem[rd_ptr] when not empty; q = 0 when empty.
  - First-word fall-through: a pushed value appears on q the cycle after the push edge.
  - No bypass: if empty, a push and q_ready in the same cycle perform a push only.
  - Follow register is held, not updated, during capture mode.
- Simultaneous push and pop:
  - Not full: both occur, count unchanged.
  - Full: the pop frees a slot, the push is accepted, count stays DEPTH and ovf is not set.
- Overflow:
  - cap = 1, full = 1 and no pop in the same cycle -> data dropped, ovf <= 1.
  - ovf stays 1 until clr or reset.
- clr = 1 (synchronous, any mode):
  - Pointers = 0, count = 0, ovf = 0, follow register = 0.
  - Takes priority over push, pop and follow update in the same cycle.
- Mode switching:
  - 1 -> 0: q shows the follow register, which still holds its last follow-mode value (or 0 after reset or clr). It tracks in from the first follow-mode edge onward. FIFO is retained.
  - 0 -> 1: q immediately shows the FIFO head, or 0 if empty.
  - mode acts combinationally on q and q_valid; it gates push and pop at the edge.
- Consumer rules:
  - q_ready with q_valid = 0 has no effect.
  - q_valid never deasserts without a pop, clr, reset or mode -> 0.

Test Plan:
- Reset and follow: rst = 0 mid-cycle -> q = 0, empty = 1, ovf = 0 without waiting for a clock edge. Release rst, mode = 0, in = 0xA5, 0x3C on successive edges -> q = 0xA5 then 0x3C, one cycle late; q_valid = 0 throughout.
- Capture order: mode = 1, cap on four edges with in = 0x11, 0x22, 0x33, 0x44, q_ready = 0 -> count = 4, full = 1, q = 0x11. Then q_ready = 1 for four edges -> q = 0x22, 0x33, 0x44, then empty = 1, q = 0.
- Overflow: FIFO full, cap with in = 0x55, q_ready = 0 -> ovf = 1, count = 4, 0x55 never appears on q. Repeat with q_ready = 1 -> 0x55 accepted, count = 4, ovf unchanged.
- Wrap-around: 10 interleaved pushes and pops with incrementing data 0x01..0x0A -> pointers wrap and q outputs 0x01..0x0A in order with none lost.
- Mode and clr: FIFO holds 2 entries, switch to mode = 0 for 3 cycles with in = 0x7E -> q = 0x7E; return to mode = 1 -> count = 2, head unchanged. Assert clr together with cap -> count = 0, ovf = 0, no push.
- Async reset mid-operation: count = 3, ovf = 1, assert rst between edges -> all outputs return to reset values at once.
